// File: rtl/rob_sched_pkg.sv
// Shared types and default widths for the R-channel release scheduler.
package rob_sched_pkg;

  localparam int unsigned DEF_NUM_UIDS      = 16;
  localparam int unsigned DEF_ID_WIDTH      = 4;
  localparam int unsigned DEF_NUM_ORIG_IDS  = 16;
  localparam int unsigned DEF_ORIG_ID_WIDTH = 4;
  localparam int unsigned DEF_ORDER_DEPTH   = 4;
  localparam int unsigned DEF_MAX_BEATS     = 8;
  localparam int unsigned DEF_DATA_WIDTH    = 64;
  localparam int unsigned DEF_RESP_WIDTH    = 2;
  localparam int unsigned DEF_CNT_WIDTH     = $clog2(DEF_MAX_BEATS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_e;

  typedef logic [DEF_ID_WIDTH-1:0]      uid_t;
  typedef logic [DEF_ORIG_ID_WIDTH-1:0] orig_id_t;
  typedef logic [DEF_CNT_WIDTH-1:0]     beat_cnt_t;

endpackage

// File: rtl/uid_order_fifo.sv
// Per-original-ID FIFO recording UID allocation order.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head (oldest UID), full, empty.
// Push is ignored when full, pop when empty; push and pop in one cycle both take effect.
module uid_order_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage needs no reset; occupancy tracking does.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/r_release_scheduler.sv
// Drains per-UID response memory to the master in legal AXI order.
// Tracks UID allocation order per original ID, beat counts and completion per UID,
// round-robins among original IDs whose oldest UID is ready, and streams that UID's
// burst to the master with the original ID restored, returning the UID on its last beat.
// Ports: clk, rst (sync, active-high); alloc_valid/alloc_ready/alloc_uid/alloc_orig_id;
// obs_fire/obs_uid/obs_last; free_req/uid_to_free/free_ack; rm_r_* (beats from memory,
// id = UID); m_r_* (beats to master, id = original ID); uid_rel_valid/uid_rel_uid; busy.
// Build option: define R_SCHED_CUT_THROUGH_EN to start draining once the head UID holds
// any beat; otherwise a UID is drained only after its last beat is stored.
module r_release_scheduler
  import rob_sched_pkg::*;
#(
  parameter int unsigned NUM_UIDS      = DEF_NUM_UIDS,
  parameter int unsigned ID_WIDTH      = DEF_ID_WIDTH,
  parameter int unsigned NUM_ORIG_IDS  = DEF_NUM_ORIG_IDS,
  parameter int unsigned ORIG_ID_WIDTH = DEF_ORIG_ID_WIDTH,
  parameter int unsigned ORDER_DEPTH   = DEF_ORDER_DEPTH,
  parameter int unsigned MAX_BEATS     = DEF_MAX_BEATS,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned RESP_WIDTH    = DEF_RESP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [ID_WIDTH-1:0]      alloc_uid,
  input  logic [ORIG_ID_WIDTH-1:0] alloc_orig_id,
  input  logic                     obs_fire,
  input  logic [ID_WIDTH-1:0]      obs_uid,
  input  logic                     obs_last,
  output logic                     free_req,
  output logic [ID_WIDTH-1:0]      uid_to_free,
  input  logic                     free_ack,
  input  logic                     rm_r_valid,
  output logic                     rm_r_ready,
  input  logic [ID_WIDTH-1:0]      rm_r_id,
  input  logic [DATA_WIDTH-1:0]    rm_r_data,
  input  logic [RESP_WIDTH-1:0]    rm_r_resp,
  input  logic                     rm_r_last,
  output logic                     m_r_valid,
  input  logic                     m_r_ready,
  output logic [ORIG_ID_WIDTH-1:0] m_r_id,
  output logic [DATA_WIDTH-1:0]    m_r_data,
  output logic [RESP_WIDTH-1:0]    m_r_resp,
  output logic                     m_r_last,
  output logic                     uid_rel_valid,
  output logic [ID_WIDTH-1:0]      uid_rel_uid,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  sched_state_e             state;
  logic [ORIG_ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0]      grant_uid;
  logic [ORIG_ID_WIDTH-1:0] grant_orig;

  logic [ID_WIDTH-1:0]      fifo_head [NUM_ORIG_IDS];
  logic [NUM_ORIG_IDS-1:0]  fifo_full;
  logic [NUM_ORIG_IDS-1:0]  fifo_empty;
  logic [NUM_ORIG_IDS-1:0]  fifo_push;
  logic [NUM_ORIG_IDS-1:0]  fifo_pop;
  logic [NUM_ORIG_IDS-1:0]  elig;

  logic [CNT_W-1:0]         beat_cnt [NUM_UIDS];
  logic [NUM_UIDS-1:0]      done;

  logic                     in_drain;
  logic                     beat_xfer;
  logic                     last_xfer;
  logic                     found;
  logic [ORIG_ID_WIDTH-1:0] win;
  int unsigned              idx;

  assign in_drain    = (state == DRAIN);
  assign alloc_ready = ~fifo_full[alloc_orig_id];
  assign uid_to_free = grant_uid;

  // Memory-to-master beat path; free_ack qualifies the memory's head beat.
  assign m_r_valid  = in_drain & rm_r_valid & free_ack;
  assign rm_r_ready = in_drain & m_r_ready & free_ack;
  assign m_r_id     = in_drain ? grant_orig : '0;
  assign m_r_data   = in_drain ? rm_r_data  : '0;
  assign m_r_resp   = in_drain ? rm_r_resp  : '0;
  assign m_r_last   = in_drain & rm_r_last;
  assign beat_xfer  = m_r_valid & m_r_ready;
  assign last_xfer  = beat_xfer & rm_r_last;

  for (genvar g = 0; g < NUM_ORIG_IDS; g++) begin : g_order
    assign fifo_push[g] = alloc_valid & alloc_ready & (alloc_orig_id == ORIG_ID_WIDTH'(g));
    assign fifo_pop[g]  = last_xfer & (grant_orig == ORIG_ID_WIDTH'(g));

    uid_order_fifo #(
      .DEPTH (ORDER_DEPTH),
      .WIDTH (ID_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[g]),
      .push_data (alloc_uid),
      .pop       (fifo_pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );

`ifdef R_SCHED_CUT_THROUGH_EN
    // A done head always still holds beats, so the OR only keeps done observable.
    assign elig[g] = ~fifo_empty[g] & ((beat_cnt[fifo_head[g]] != '0) | done[fifo_head[g]]);
`else
    assign elig[g] = ~fifo_empty[g] & done[fifo_head[g]] & (beat_cnt[fifo_head[g]] != '0);
`endif
  end

  // Stored-minus-popped beat count per UID; simultaneous +1/-1 cancel.
  for (genvar u = 0; u < NUM_UIDS; u++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = obs_fire & (obs_uid == ID_WIDTH'(u));
    assign dec = beat_xfer & (rm_r_id == ID_WIDTH'(u));

    always_ff @(posedge clk) begin
      if (rst)              beat_cnt[u] <= '0;
      else if (inc && !dec) beat_cnt[u] <= beat_cnt[u] + CNT_W'(1);
      else if (dec && !inc) beat_cnt[u] <= beat_cnt[u] - CNT_W'(1);
    end
  end

  // Completion flags: set when the last beat is stored, cleared when it is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= '0;
    end else begin
      done <= (done & ~(NUM_UIDS'(last_xfer) << rm_r_id))
            | (NUM_UIDS'(obs_fire & obs_last) << obs_uid);
    end
  end

  // Round-robin scan starting at rr_ptr; first eligible ID wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_ORIG_IDS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_ORIG_IDS) idx = idx - NUM_ORIG_IDS;
      if (!found && elig[ORIG_ID_WIDTH'(idx)]) begin
        found = 1'b1;
        win   = ORIG_ID_WIDTH'(idx);
      end
    end
  end

  // Grant / drain sequencer with registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_uid     <= '0;
      grant_orig    <= '0;
      free_req      <= 1'b0;
      busy          <= 1'b0;
      uid_rel_valid <= 1'b0;
      uid_rel_uid   <= '0;
    end else begin
      uid_rel_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= DRAIN;
            grant_uid  <= fifo_head[win];
            grant_orig <= win;
            free_req   <= 1'b1;
            busy       <= 1'b1;
            rr_ptr     <= (win == ORIG_ID_WIDTH'(NUM_ORIG_IDS - 1)) ? '0 : win + ORIG_ID_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (last_xfer) begin
            state         <= IDLE;
            free_req      <= 1'b0;
            busy          <= 1'b0;
            uid_rel_valid <= 1'b1;
            uid_rel_uid   <= grant_uid;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_release_scheduler.sv
// Scoreboard bench for r_release_scheduler: expected master beats and UID returns are
// queued as stimulus is issued; a monitor pops and compares on every output event.
module tb_r_release_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_uid;
  logic [3:0]  alloc_orig_id;
  logic        obs_fire;
  logic [3:0]  obs_uid;
  logic        obs_last;
  logic [63:0] obs_data;
  logic        free_req;
  logic [3:0]  uid_to_free;
  logic        free_ack;
  logic        rm_r_valid;
  logic        rm_r_ready;
  logic [3:0]  rm_r_id;
  logic [63:0] rm_r_data;
  logic [1:0]  rm_r_resp;
  logic        rm_r_last;
  logic        m_r_valid;
  logic        m_r_ready;
  logic [3:0]  m_r_id;
  logic [63:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic        uid_rel_valid;
  logic [3:0]  uid_rel_uid;
  logic        busy;

  always #5 clk = ~clk;

  r_release_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_uid     (alloc_uid),
    .alloc_orig_id (alloc_orig_id),
    .obs_fire      (obs_fire),
    .obs_uid       (obs_uid),
    .obs_last      (obs_last),
    .free_req      (free_req),
    .uid_to_free   (uid_to_free),
    .free_ack      (free_ack),
    .rm_r_valid    (rm_r_valid),
    .rm_r_ready    (rm_r_ready),
    .rm_r_id       (rm_r_id),
    .rm_r_data     (rm_r_data),
    .rm_r_resp     (rm_r_resp),
    .rm_r_last     (rm_r_last),
    .m_r_valid     (m_r_valid),
    .m_r_ready     (m_r_ready),
    .m_r_id        (m_r_id),
    .m_r_data      (m_r_data),
    .m_r_resp      (m_r_resp),
    .m_r_last      (m_r_last),
    .uid_rel_valid (uid_rel_valid),
    .uid_rel_uid   (uid_rel_uid),
    .busy          (busy)
  );

  // Response memory model: one beat queue per UID, head presented while free_req.
  logic [63:0] mem_data [16][16];
  logic        mem_last [16][16];
  logic [3:0]  wr_ptr [16];
  logic [3:0]  rd_ptr [16];

  assign rm_r_valid = free_req && (wr_ptr[uid_to_free] != rd_ptr[uid_to_free]);
  assign free_ack   = rm_r_valid;
  assign rm_r_id    = uid_to_free;
  assign rm_r_data  = mem_data[uid_to_free][rd_ptr[uid_to_free]];
  assign rm_r_last  = mem_last[uid_to_free][rd_ptr[uid_to_free]];
  assign rm_r_resp  = uid_to_free[1:0];

  always @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < 16; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
      end
    end else begin
      if (obs_fire) begin
        mem_data[obs_uid][wr_ptr[obs_uid]] <= obs_data;
        mem_last[obs_uid][wr_ptr[obs_uid]] <= obs_last;
        wr_ptr[obs_uid] <= wr_ptr[obs_uid] + 4'd1;
      end
      if (rm_r_valid && rm_r_ready) rd_ptr[uid_to_free] <= rd_ptr[uid_to_free] + 4'd1;
    end
  end

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      exp_q [$];
  logic [3:0] rel_q [$];
  beat_t      mon_e;
  logic [3:0] mon_u;
  int         n_vec = 0;
  int         n_err = 0;
  int         beats_seen = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dat(input logic [3:0] u, input int b);
    return {16'hBEEF, 12'h000, u, 24'h000000, 8'(b)};
  endfunction

  // Monitor: compares every master beat and UID return against the queues.
  always @(negedge clk) begin
    if (!rst && m_r_valid && m_r_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL m_r_unexpected: got id %h data %h, expected no beat", m_r_id, m_r_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_r_beat", 72'({m_r_id, m_r_data, m_r_resp, m_r_last}), 72'(mon_e));
      end
    end
    if (!rst && uid_rel_valid) begin
      if (rel_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL uid_rel_unexpected: got uid %h, expected no release", uid_rel_uid);
      end else begin
        mon_u = rel_q.pop_front();
        chk("uid_rel_uid", 72'(uid_rel_uid), 72'(mon_u));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] uid, input logic [3:0] orig);
    alloc_valid   = 1'b1;
    alloc_uid     = uid;
    alloc_orig_id = orig;
    #1;
    chk("alloc_ready_alloc", 72'(alloc_ready), 72'(1));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic store(input logic [3:0] uid, input int from, input int cnt, input int total);
    for (int b = from; b < from + cnt; b++) begin
      obs_fire = 1'b1;
      obs_uid  = uid;
      obs_last = (b == total - 1);
      obs_data = dat(uid, b);
      tick();
    end
    obs_fire = 1'b0;
    obs_last = 1'b0;
  endtask

  task automatic expect_burst(input logic [3:0] uid, input int n, input logic [3:0] orig);
    logic [3:0] u;
    u = uid;
    for (int b = 0; b < n; b++)
      exp_q.push_back('{id: orig, data: dat(uid, b), resp: u[1:0], last: (b == n - 1)});
    rel_q.push_back(uid);
  endtask

  task automatic wait_drained(input int max_cycles);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rel_q.size() != 0 || busy) && c < max_cycles) begin
      tick();
      c++;
    end
    chk("drain_complete", 72'(exp_q.size() + rel_q.size() + int'(busy)), 72'(0));
  endtask

  initial begin
    int c;
    int start;
    rst = 1'b1; alloc_valid = 1'b0; alloc_uid = '0; alloc_orig_id = '0;
    obs_fire = 1'b0; obs_uid = '0; obs_last = 1'b0; obs_data = '0; m_r_ready = 1'b1;
    repeat (2) tick();
    chk("rst_free_req", 72'(free_req), 72'(0));
    chk("rst_uid_to_free", 72'(uid_to_free), 72'(0));
    chk("rst_m_r_valid", 72'(m_r_valid), 72'(0));
    chk("rst_m_r_id", 72'(m_r_id), 72'(0));
    chk("rst_uid_rel", 72'({uid_rel_valid, uid_rel_uid}), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_alloc_ready", 72'(alloc_ready), 72'(1));
    rst = 1'b0;
    tick();

    // Single 4-beat burst: UID 3 on original ID 5.
    alloc(4'd3, 4'd5);
    expect_burst(4'd3, 4, 4'd5);
    store(4'd3, 0, 4, 4);
`ifndef R_SCHED_CUT_THROUGH_EN
    chk("t1_no_req_yet", 72'(free_req), 72'(0));
    tick();
    chk("t1_free_req", 72'({free_req, uid_to_free, m_r_id, busy}), 72'({1'b1, 4'd3, 4'd5, 1'b1}));
    repeat (4) tick();
    chk("t1_uid_rel", 72'({uid_rel_valid, uid_rel_uid, busy}), 72'({1'b1, 4'd3, 1'b0}));
`endif
    wait_drained(40);

    // In-order release within original ID 2: UID 7 completes first but waits for UID 1.
    alloc(4'd1, 4'd2);
    alloc(4'd7, 4'd2);
    store(4'd7, 0, 2, 2);
    repeat (3) tick();
    chk("t2_blocked", 72'(free_req), 72'(0));
    expect_burst(4'd1, 3, 4'd2);
    expect_burst(4'd7, 2, 4'd2);
    store(4'd1, 0, 3, 3);
    wait_drained(60);

    // Round robin: blocker on ID 9 holds the drain while IDs 0 and 4 become eligible.
    alloc(4'd9, 4'd9);
    alloc(4'd0, 4'd0);
    alloc(4'd4, 4'd4);
    m_r_ready = 1'b0;
    expect_burst(4'd9, 1, 4'd9);
    store(4'd9, 0, 1, 1);
    repeat (2) tick();
    expect_burst(4'd0, 2, 4'd0);
    expect_burst(4'd4, 2, 4'd4);
    store(4'd0, 0, 2, 2);
    store(4'd4, 0, 2, 2);
    m_r_ready = 1'b1;
    wait_drained(60);
    // rr_ptr is now 5; a blocker on ID 3 leaves rr_ptr at 4, so ID 4 now precedes ID 0.
    alloc(4'd3, 4'd3);
    alloc(4'd0, 4'd0);
    alloc(4'd4, 4'd4);
    m_r_ready = 1'b0;
    expect_burst(4'd3, 1, 4'd3);
    store(4'd3, 0, 1, 1);
    repeat (2) tick();
    expect_burst(4'd4, 2, 4'd4);
    expect_burst(4'd0, 2, 4'd0);
    store(4'd0, 0, 2, 2);
    store(4'd4, 0, 2, 2);
    m_r_ready = 1'b1;
    wait_drained(60);

    // Order FIFO full on ID 6 back-pressures only ID 6.
    alloc(4'd10, 4'd6);
    alloc(4'd11, 4'd6);
    alloc(4'd12, 4'd6);
    alloc(4'd13, 4'd6);
    alloc_orig_id = 4'd6;
    #1 chk("t4_full_orig6", 72'(alloc_ready), 72'(0));
    alloc_orig_id = 4'd7;
    #1 chk("t4_free_orig7", 72'(alloc_ready), 72'(1));
    expect_burst(4'd10, 1, 4'd6);
    store(4'd10, 0, 1, 1);
    wait_drained(40);
    alloc_orig_id = 4'd6;
    #1 chk("t4_pop_restores", 72'(alloc_ready), 72'(1));
    alloc(4'd14, 4'd6);
    expect_burst(4'd11, 1, 4'd6);
    expect_burst(4'd12, 1, 4'd6);
    expect_burst(4'd13, 1, 4'd6);
    expect_burst(4'd14, 1, 4'd6);
    store(4'd11, 0, 1, 1);
    store(4'd12, 0, 1, 1);
    store(4'd13, 0, 1, 1);
    store(4'd14, 0, 1, 1);
    wait_drained(60);

    // 8-beat burst with master ready toggling every cycle.
    alloc(4'd8, 4'd3);
    expect_burst(4'd8, 8, 4'd3);
    store(4'd8, 0, 8, 8);
    start = beats_seen;
    c = 0;
    while ((exp_q.size() != 0 || rel_q.size() != 0 || busy) && c < 80) begin
      m_r_ready = c[0];
      tick();
      c++;
    end
    m_r_ready = 1'b1;
    chk("t5_beat_count", 72'(beats_seen - start), 72'(8));
    wait_drained(10);

    // Reset in the middle of an 8-beat drain.
    alloc(4'd5, 4'd1);
    expect_burst(4'd5, 8, 4'd1);
    store(4'd5, 0, 8, 8);
    start = beats_seen;
    c = 0;
    while (beats_seen < start + 3 && c < 40) begin
      tick();
      c++;
    end
    chk("t6_partial_beats", 72'(beats_seen >= start + 3), 72'(1));
    rst = 1'b1;
    exp_q.delete();
    rel_q.delete();
    alloc_orig_id = 4'd1;
    tick();
    chk("t6_rst_free_req", 72'({free_req, busy, m_r_valid}), 72'(0));
    chk("t6_rst_alloc_ready", 72'(alloc_ready), 72'(1));
    rst = 1'b0;
    tick();
    alloc(4'd5, 4'd1);
    expect_burst(4'd5, 1, 4'd1);
    store(4'd5, 0, 1, 1);
    wait_drained(40);

`ifdef R_SCHED_CUT_THROUGH_EN
    // Cut-through: drain begins once the first beat of UID 6 is stored.
    alloc(4'd6, 4'd8);
    expect_burst(4'd6, 3, 4'd8);
    store(4'd6, 0, 1, 3);
    tick();
    chk("t7_cut_through_req", 72'({free_req, uid_to_free}), 72'({1'b1, 4'd6}));
    store(4'd6, 1, 2, 3);
    wait_drained(40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
